metricas_tempo: RTL and testbench

- Downstream consumer of the game datapath's reaction-time timer, count value 0..9999 at 1 ms per tick.
- Accumulates the response time of each completed play and keeps the best (minimum) time.
- Computes the running average response time with a sequential restoring divider.
- Outputs feed the metrics display mux and the control unit's end-of-game report.

---
 rtl/metricas_tempo_pkg.sv | 20 ++
 rtl/metricas_tempo_divisor_seq.sv | 64 ++++++
 rtl/metricas_tempo.sv | 166 ++++++++++++++++
 tb/tb_metricas_tempo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/metricas_tempo_pkg.sv
// Shared widths, timer modulus and FSM encoding for the response-time metrics block.
package metricas_tempo_pkg;

   localparam int TW   = 14;
   localparam int CW   = 4;
   localparam int TMAX = 10000;
   localparam int SW   = TW + CW;

   typedef enum logic [1:0] {
      OCIOSO = 2'b00,
      DIVIDE = 2'b01,
      FIM    = 2'b10
   } estado_t;

   // Timer values at or beyond the modulus are treated as the slowest valid time.
   function automatic logic [TW-1:0] satura(input logic [TW-1:0] v);
      return (v >= TW'(TMAX)) ? TW'(TMAX - 1) : v;
   endfunction

endpackage

// File: rtl/metricas_tempo_divisor_seq.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// fim_o flags the step that produces the last quotient bit.
module divisor_seq
   import metricas_tempo_pkg::*;
(
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          inicia_i,
   input  logic [SW-1:0] dividendo_i,
   input  logic [CW-1:0] divisor_i,
   output logic [SW-1:0] quociente_o,
   output logic          fim_o
);

   localparam int NW = $clog2(SW + 1);

   logic [SW-1:0] quoc_q, quoc_d;
   logic [CW-1:0] resto_q, resto_d;
   logic [CW-1:0] div_q, div_d;
   logic [NW-1:0] cont_q, cont_d;
   logic [CW:0]   parcial;

   // The dividend register shifts out its MSB as quotient bits shift in at the bottom.
   always_comb begin
      quoc_d  = quoc_q;
      resto_d = resto_q;
      div_d   = div_q;
      cont_d  = cont_q;
      parcial = {resto_q, quoc_q[SW-1]};
      if (inicia_i) begin
         quoc_d  = dividendo_i;
         resto_d = '0;
         div_d   = divisor_i;
         cont_d  = NW'(SW);
      end else if (cont_q != '0) begin
         if (parcial >= {1'b0, div_q}) begin
            resto_d = CW'(parcial - {1'b0, div_q});
            quoc_d  = {quoc_q[SW-2:0], 1'b1};
         end else begin
            resto_d = parcial[CW-1:0];
            quoc_d  = {quoc_q[SW-2:0], 1'b0};
         end
         cont_d = cont_q - NW'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         quoc_q  <= '0;
         resto_q <= '0;
         div_q   <= '0;
         cont_q  <= '0;
      end else begin
         quoc_q  <= quoc_d;
         resto_q <= resto_d;
         div_q   <= div_d;
         cont_q  <= cont_d;
      end
   end

   assign quociente_o = quoc_q;
   assign fim_o       = (cont_q == NW'(1));

endmodule

// File: rtl/metricas_tempo.sv
// Response-time metrics: sample count, timeouts, best time and running average.
// state  | meaning
// OCIOSO | idle, waiting for a sample (or draining the pending buffer)
// DIVIDE | divider producing the average, one bit per clock
// FIM    | average latched, pronto pulsed, pending sample may restart
module metricas_tempo
   import metricas_tempo_pkg::*;
(
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          limpa_i,
   input  logic          registra_i,
   input  logic [TW-1:0] tempo_i,
   input  logic          timeout_i,
   output logic [TW-1:0] media_o,
   output logic [TW-1:0] melhor_o,
   output logic [CW-1:0] qtd_o,
   output logic [CW-1:0] qtd_timeout_o,
   output logic          ocupado_o,
   output logic          pronto_o,
   output logic          cheio_o,
   output logic          perdido_o
);

   localparam logic [CW-1:0] QMAX = '1;

   estado_t       estado_q, estado_d;
   logic [SW-1:0] soma_q, soma_d;
   logic [CW-1:0] qtd_q, qtd_d, qto_q, qto_d;
   logic [TW-1:0] melhor_q, melhor_d, media_q, media_d;
   logic          pronto_q, pronto_d, cheio_q, cheio_d, perdido_q, perdido_d;
   logic          pend_v_q, pend_v_d, pend_to_q, pend_to_d;
   logic [TW-1:0] pend_t_q, pend_t_d;

   logic          inicia, fim_div, usa_pend, usa_in, am_v, am_to;
   logic [TW-1:0] am_t, t_sat;
   logic [SW-1:0] dividendo, quociente;
   logic [CW-1:0] divisor;

   divisor_seq u_div (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .inicia_i    (inicia),
      .dividendo_i (dividendo),
      .divisor_i   (divisor),
      .quociente_o (quociente),
      .fim_o       (fim_div)
   );

   always_comb begin
      estado_d  = estado_q;
      soma_d    = soma_q;
      qtd_d     = qtd_q;
      qto_d     = qto_q;
      melhor_d  = melhor_q;
      media_d   = media_q;
      pronto_d  = 1'b0;
      cheio_d   = cheio_q;
      perdido_d = perdido_q;
      pend_v_d  = pend_v_q;
      pend_t_d  = pend_t_q;
      pend_to_d = pend_to_q;
      inicia    = 1'b0;
      dividendo = soma_q;
      divisor   = qtd_q;

      // A buffered sample always goes before a fresh one; consuming it frees the slot.
      usa_pend = pend_v_q && (estado_q != DIVIDE);
      usa_in   = registra_i && (estado_q == OCIOSO) && !pend_v_q;
      am_v     = usa_pend || usa_in;
      am_t     = usa_pend ? pend_t_q : tempo_i;
      am_to    = usa_pend ? pend_to_q : timeout_i;
      t_sat    = satura(am_t);

      if (usa_pend) pend_v_d = 1'b0;
      if (registra_i && !usa_in) begin
         if (!pend_v_q || usa_pend) begin
            pend_v_d  = 1'b1;
            pend_t_d  = tempo_i;
            pend_to_d = timeout_i;
         end else begin
            perdido_d = 1'b1;
         end
      end

      case (estado_q)
         DIVIDE: if (fim_div) estado_d = FIM;
         FIM: begin
            media_d  = quociente[TW-1:0];
            pronto_d = 1'b1;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase

      if (am_v) begin
         if (am_to) begin
            if (qto_q != QMAX) qto_d = qto_q + CW'(1);
         end else if (qtd_q == QMAX) begin
            cheio_d = 1'b1;
         end else begin
            soma_d = soma_q + SW'(t_sat);
            qtd_d  = qtd_q + CW'(1);
            if (t_sat < melhor_q) melhor_d = t_sat;
            inicia    = 1'b1;
            dividendo = soma_d;
            divisor   = qtd_d;
            estado_d  = DIVIDE;
         end
      end

      if (limpa_i) begin
         estado_d  = OCIOSO;
         soma_d    = '0;
         qtd_d     = '0;
         qto_d     = '0;
         melhor_d  = '1;
         media_d   = '0;
         pronto_d  = 1'b0;
         cheio_d   = 1'b0;
         perdido_d = 1'b0;
         pend_v_d  = 1'b0;
         inicia    = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         estado_q  <= OCIOSO;
         soma_q    <= '0;
         qtd_q     <= '0;
         qto_q     <= '0;
         melhor_q  <= '1;
         media_q   <= '0;
         pronto_q  <= 1'b0;
         cheio_q   <= 1'b0;
         perdido_q <= 1'b0;
         pend_v_q  <= 1'b0;
         pend_t_q  <= '0;
         pend_to_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         soma_q    <= soma_d;
         qtd_q     <= qtd_d;
         qto_q     <= qto_d;
         melhor_q  <= melhor_d;
         media_q   <= media_d;
         pronto_q  <= pronto_d;
         cheio_q   <= cheio_d;
         perdido_q <= perdido_d;
         pend_v_q  <= pend_v_d;
         pend_t_q  <= pend_t_d;
         pend_to_q <= pend_to_d;
      end
   end

   assign media_o       = media_q;
   assign melhor_o      = melhor_q;
   assign qtd_o         = qtd_q;
   assign qtd_timeout_o = qto_q;
   assign ocupado_o     = (estado_q != OCIOSO);
   assign pronto_o      = pronto_q;
   assign cheio_o       = cheio_q;
   assign perdido_o     = perdido_q;

endmodule

// File: tb/tb_metricas_tempo.sv
// Directed bench for metricas_tempo: vector table for single plays, hand sequences for corners.
module tb_metricas_tempo;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        limpa = 1'b0;
   logic        registra = 1'b0;
   logic [13:0] tempo = '0;
   logic        timeout = 1'b0;
   logic [13:0] media, melhor;
   logic [3:0]  qtd, qtd_timeout;
   logic        ocupado, pronto, cheio, perdido;

   int n_tests = 0;
   int n_fail  = 0;

   metricas_tempo dut (
      .clock_i       (clock),
      .reset_i       (reset),
      .limpa_i       (limpa),
      .registra_i    (registra),
      .tempo_i       (tempo),
      .timeout_i     (timeout),
      .media_o       (media),
      .melhor_o      (melhor),
      .qtd_o         (qtd),
      .qtd_timeout_o (qtd_timeout),
      .ocupado_o     (ocupado),
      .pronto_o      (pronto),
      .cheio_o       (cheio),
      .perdido_o     (perdido)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [13:0] tempo;
      logic        to;
      logic        limpa_antes;
      int          lat;
      int          media;
      int          melhor;
      int          qtd;
      int          qto;
   } vetor_t;

   vetor_t tab[5];

   task automatic verifica(input string nome, input int atual, input int esperado);
      n_tests++;
      if (atual != esperado) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
      end
   endtask

   task automatic faz_limpa();
      @(posedge clock); #1 limpa = 1'b1;
      @(posedge clock); #1 limpa = 1'b0;
   endtask

   // lat = number of edges after the registra edge until pronto is seen, 0 if never within 40.
   task automatic envia(input logic [13:0] t, input logic to, output int lat);
      lat = 0;
      @(posedge clock); #1;
      registra = 1'b1; tempo = t; timeout = to;
      @(posedge clock); #1;
      registra = 1'b0; timeout = 1'b0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clock); #1;
         if (pronto) lat = k;
      end
   endtask

   initial begin
      int lat, npr, p1, p2;

      tab[0] = '{14'd1000,  1'b0, 1'b0, 19, 1000, 1000, 1, 0};
      tab[1] = '{14'd2000,  1'b0, 1'b0, 19, 1500, 1000, 2, 0};
      tab[2] = '{14'd3000,  1'b0, 1'b0, 19, 2000, 1000, 3, 0};
      tab[3] = '{14'd9999,  1'b1, 1'b0, 0,  2000, 1000, 3, 1};
      tab[4] = '{14'd12000, 1'b0, 1'b1, 19, 9999, 9999, 1, 0};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      npr = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         if (pronto) npr++;
      end
      verifica("reset_pronto", npr, 0);
      verifica("reset_media", int'(media), 0);
      verifica("reset_melhor", int'(melhor), 16383);
      verifica("reset_qtd", int'(qtd), 0);
      verifica("reset_qto", int'(qtd_timeout), 0);
      verifica("reset_ocupado", int'(ocupado), 0);
      verifica("reset_flags", int'({cheio, perdido}), 0);

      for (int i = 0; i < 5; i++) begin
         if (tab[i].limpa_antes) faz_limpa();
         envia(tab[i].tempo, tab[i].to, lat);
         verifica($sformatf("v%0d_lat", i), lat, tab[i].lat);
         verifica($sformatf("v%0d_media", i), int'(media), tab[i].media);
         verifica($sformatf("v%0d_melhor", i), int'(melhor), tab[i].melhor);
         verifica($sformatf("v%0d_qtd", i), int'(qtd), tab[i].qtd);
         verifica($sformatf("v%0d_qto", i), int'(qtd_timeout), tab[i].qto);
         if (tab[i].lat != 0) begin
            @(posedge clock); #1;
            verifica($sformatf("v%0d_pronto_pulso", i), int'(pronto), 0);
         end
         repeat (10) @(posedge clock);
      end

      // Back-to-back plays: one in flight, one buffered, one lost.
      faz_limpa();
      @(posedge clock); #1;
      registra = 1'b1; tempo = 14'd300;
      @(posedge clock); #1 tempo = 14'd600;
      @(posedge clock); #1 tempo = 14'd900;
      @(posedge clock); #1 registra = 1'b0;
      npr = 0; p1 = 0; p2 = 0;
      for (int k = 3; k <= 60; k++) begin
         @(posedge clock); #1;
         if (pronto) begin
            npr++;
            if (p1 == 0) p1 = k; else p2 = k;
         end
      end
      verifica("rajada_npronto", npr, 2);
      verifica("rajada_lat1", p1, 19);
      verifica("rajada_lat2", p2, 38);
      verifica("rajada_media", int'(media), 450);
      verifica("rajada_melhor", int'(melhor), 300);
      verifica("rajada_qtd", int'(qtd), 2);
      verifica("rajada_perdido", int'(perdido), 1);

      // Fill the sample counter and push one more.
      faz_limpa();
      for (int i = 0; i < 15; i++) begin
         envia(14'd500, 1'b0, lat);
         verifica($sformatf("cheio_lat%0d", i), lat, 19);
      end
      verifica("cheio_antes", int'(cheio), 0);
      envia(14'd500, 1'b0, lat);
      verifica("cheio_lat16", lat, 0);
      verifica("cheio_flag", int'(cheio), 1);
      verifica("cheio_qtd", int'(qtd), 15);
      verifica("cheio_media", int'(media), 500);
      verifica("cheio_soma", int'(dut.soma_q), 7500);

      // Abort a division in flight.
      faz_limpa();
      @(posedge clock); #1;
      registra = 1'b1; tempo = 14'd1234;
      @(posedge clock); #1 registra = 1'b0;
      repeat (4) @(posedge clock);
      #1 limpa = 1'b1;
      @(posedge clock); #1 limpa = 1'b0;
      verifica("aborta_ocupado", int'(ocupado), 0);
      verifica("aborta_media", int'(media), 0);
      verifica("aborta_melhor", int'(melhor), 16383);
      verifica("aborta_qtd", int'(qtd), 0);
      verifica("aborta_flags", int'({cheio, perdido, pronto}), 0);
      npr = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clock); #1;
         if (pronto) npr++;
      end
      verifica("aborta_sem_pronto", npr, 0);
      envia(14'd700, 1'b0, lat);
      verifica("apos_aborta_lat", lat, 19);
      verifica("apos_aborta_media", int'(media), 700);
      verifica("apos_aborta_melhor", int'(melhor), 700);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
